// File: rtl/clk_sel_ctrl.sv
// Clock-select controller for the glitch-free mux: drives the mux select line,
// refuses switches to a dead clk2 and reverts to clk1 when clk2 stops while selected.
module clk_sel_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int ALIVE_WINDOW  = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic clk1,
    input  logic rst,
    input  logic clk2,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic select,
    output logic busy,
    output logic done,
    output logic err,
    output logic fallback,
    output logic clk2_alive
);
    localparam int CW = $clog2(ALIVE_WINDOW + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] ALIVE_MAX   = CW'(ALIVE_WINDOW);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          scnt_q, scnt_d;
    logic                   select_q, select_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   fallback_q, fallback_d;
    logic                   t2_q, t2_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [CW-1:0]          acnt_q, acnt_d;
    logic                   alive_q, alive_d;
    logic                   toggle;
    logic                   dead_sel;

    // The only logic clocked by clk2: a free-running toggle.
    always_comb t2_d = ~t2_q;

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) t2_q <= 1'b0;
        else     t2_q <= t2_d;
    end

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], t2_q};
        edge_d = sync_q[SYNC_STAGES-1];
        toggle = sync_q[SYNC_STAGES-1] ^ edge_q;
        if (toggle)                   acnt_d = '0;
        else if (acnt_q != ALIVE_MAX) acnt_d = acnt_q + CW'(1);
        else                          acnt_d = acnt_q;
        alive_d = (acnt_d < ALIVE_MAX);
    end

    always_comb begin
        dead_sel   = select_q && !alive_q;
        req_ready  = (state_q == IDLE) && !dead_sel;
        state_d    = state_q;
        scnt_d     = scnt_q;
        select_d   = select_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        fallback_d = 1'b0;
        // Losing the selected clock overrides any request or settle in flight.
        if (dead_sel) begin
            select_d   = 1'b0;
            fallback_d = 1'b1;
            state_d    = IDLE;
            scnt_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (req_sel == select_q) begin
                            done_d = 1'b1;
                        end else if (req_sel && !alive_q) begin
                            err_d = 1'b1;
                        end else begin
                            select_d = req_sel;
                            scnt_d   = SETTLE_INIT;
                            state_d  = SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (scnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        scnt_d = scnt_q - SW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            edge_q     <= 1'b0;
            acnt_q     <= ALIVE_MAX;
            alive_q    <= 1'b0;
            state_q    <= IDLE;
            scnt_q     <= '0;
            select_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fallback_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            edge_q     <= edge_d;
            acnt_q     <= acnt_d;
            alive_q    <= alive_d;
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            select_q   <= select_d;
            done_q     <= done_d;
            err_q      <= err_d;
            fallback_q <= fallback_d;
        end
    end

    assign select     = select_q;
    assign busy       = (state_q == SETTLE);
    assign done       = done_q;
    assign err        = err_q;
    assign fallback   = fallback_q;
    assign clk2_alive = alive_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Bench for clk_sel_ctrl: two instances (settle 8 and settle 1) share stimulus and
// are checked each cycle against a window/deadline model, plus literal timing pins.
module tb_clk_sel_ctrl;
    localparam int SYNC = 2;
    localparam int WIN  = 16;

    logic clk1 = 1'b0, clk2 = 1'b0, rst = 1'b1, req_valid = 1'b0, req_sel = 1'b0;
    logic [1:0] rdy, sel, bsy, dn, er, fb, alv;
    int nvec = 0, nerr = 0;

    bit c2_en = 1'b0;
    int c2_half = 15;

    always #5 clk1 = ~clk1;

    // clk2 edges land 2 ns / 7 ns past a clk1 edge, never on one.
    initial begin
        forever begin
            wait (c2_en);
            @(posedge clk1);
            #2;
            while (c2_en) begin
                clk2 = 1'b1; #(c2_half);
                clk2 = 1'b0; #(c2_half);
            end
        end
    end

    clk_sel_ctrl #(.SYNC_STAGES(SYNC), .ALIVE_WINDOW(WIN), .SETTLE_CYCLES(8)) u_dut0 (
        .clk1(clk1), .rst(rst), .clk2(clk2), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(rdy[0]), .select(sel[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0]),
        .fallback(fb[0]), .clk2_alive(alv[0]));

    clk_sel_ctrl #(.SYNC_STAGES(SYNC), .ALIVE_WINDOW(WIN), .SETTLE_CYCLES(1)) u_dut1 (
        .clk1(clk1), .rst(rst), .clk2(clk2), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(rdy[1]), .select(sel[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1]),
        .fallback(fb[1]), .clk2_alive(alv[1]));

    // Reference model: clk2 phase sampled at every clk1 edge; liveness = any sampled
    // change seen (after sync delay) within the last WIN edges; settle = absolute deadline.
    bit t2m;
    bit hist[$];
    int k;
    bit m_alive;
    bit m_sel [2];
    int m_due [2];
    bit m_done[2], m_err[2], m_fb[2];
    bit md_dead, md_rdy;

    function automatic int settle_of(input int i);
        return (i == 0) ? 8 : 1;
    endfunction

    function automatic bit samp(input int j);
        if (j < 0 || j >= hist.size()) return 1'b0;
        return hist[j];
    endfunction

    always @(posedge clk2 or posedge rst) begin
        if (rst) t2m = 1'b0;
        else     t2m = ~t2m;
    end

    always @(posedge clk1 or posedge rst) begin
        if (rst) begin
            k = 0;
            hist.delete();
            m_alive = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_sel[i] = 1'b0; m_due[i] = -1;
                m_done[i] = 1'b0; m_err[i] = 1'b0; m_fb[i] = 1'b0;
            end
        end else begin
            hist.push_back(t2m);
            for (int i = 0; i < 2; i++) begin
                md_dead = m_sel[i] && !m_alive;
                md_rdy  = (m_due[i] < 0) && !md_dead;
                m_done[i] = 1'b0; m_err[i] = 1'b0; m_fb[i] = 1'b0;
                if (md_dead) begin
                    m_sel[i] = 1'b0; m_fb[i] = 1'b1; m_due[i] = -1;
                end else if (md_rdy && req_valid) begin
                    if (req_sel == m_sel[i])          m_done[i] = 1'b1;
                    else if (req_sel && !m_alive)     m_err[i] = 1'b1;
                    else begin
                        m_sel[i] = req_sel;
                        m_due[i] = k + settle_of(i);
                    end
                end else if (m_due[i] >= 0 && k == m_due[i]) begin
                    m_done[i] = 1'b1; m_due[i] = -1;
                end
            end
            m_alive = 1'b0;
            for (int t = k - WIN + 1; t <= k; t++)
                if (samp(t - SYNC) != samp(t - SYNC - 1)) m_alive = 1'b1;
            k++;
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int lo, input int hi);
        nvec++;
        if (act < lo || act > hi) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", nm, act, lo, hi, $time);
        end
    endtask

    // Per-cycle compare of {ready, select, busy, done, err, fallback, alive}.
    logic [6:0] act_v, exp_v;
    always @(negedge clk1) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                act_v = {rdy[i], sel[i], bsy[i], dn[i], er[i], fb[i], alv[i]};
                exp_v = {(m_due[i] < 0) && !(m_sel[i] && !m_alive), m_sel[i],
                         (m_due[i] >= 0), m_done[i], m_err[i], m_fb[i], m_alive};
                nvec++;
                if (act_v !== exp_v) begin
                    nerr++;
                    $display("FAIL outs[%0d] {rdy,sel,busy,done,err,fb,alive}: got %b expected %b at %0t",
                             i, act_v, exp_v, $time);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk1);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int j;
    bit bad;

    initial begin
        // 1: reset with clk2 idle; a clk2 request is refused.
        step(3);
        rst = 1'b0;
        step();
        chk("reset_select", sel[0], 1'b0);
        chk("reset_alive", alv[0], 1'b0);
        chk("reset_ready", rdy[0], 1'b1);
        chk("reset_pulses", dn[0] | er[0] | fb[0] | bsy[0], 1'b0);
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        chk("dead_req_err0", er[0], 1'b1);
        chk("dead_req_err1", er[1], 1'b1);
        chk("dead_req_sel", sel[0], 1'b0);
        step();
        chk("err_one_cycle", er[0], 1'b0);

        // 2: clk2 at 3x the clk1 period, then switch to it.
        c2_half = 15; c2_en = 1'b1;
        j = 0;
        while (!alv[0] && j < 10) begin step(); j++; end
        chk_int("alive_latency", j, 1, 5);
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        chk("switch_sel_at_accept", sel[0], 1'b1);
        chk("switch_busy", bsy[0], 1'b1);
        chk("switch_not_ready", rdy[0], 1'b0);
        j = 0;
        do begin step(); j++; end while (!dn[0] && j < 20);
        chk_int("settle_latency", j, 8, 8);
        chk("ready_after_done", rdy[0], 1'b1);

        // 4: same-source request, then a request held across SETTLE.
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        chk("same_sel_done", dn[0], 1'b1);
        chk("same_sel_keep", sel[0], 1'b1);
        chk("same_sel_nobusy", bsy[0], 1'b0);
        req_valid = 1'b1; req_sel = 1'b0;
        step();
        req_sel = 1'b1;
        chk("to_clk1_sel", sel[0], 1'b0);
        bad = 1'b0; j = 0;
        do begin step(); j++; if (sel[0]) bad = 1'b1; end while (!dn[0] && j < 20);
        chk_int("settle_latency2", j, 8, 8);
        chk("no_accept_in_settle", bad, 1'b0);
        step();
        req_valid = 1'b0;
        chk("accept_in_done_cycle", sel[0], 1'b1);
        j = 0;
        do begin step(); j++; end while (!dn[0] && j < 20);

        // 3: clk2 dies while selected; held request is not taken in the fallback cycle.
        req_valid = 1'b1; req_sel = 1'b1;
        c2_en = 1'b0;
        j = 0;
        while (!fb[0] && j < 40) begin step(); j++; end
        chk_int("fallback_latency", j, 12, 28);
        chk("fallback_sel", sel[0], 1'b0);
        chk("fallback_no_done", dn[0], 1'b0);
        chk("fallback_no_err", er[0], 1'b0);
        step();
        chk("fallback_one_cycle", fb[0], 1'b0);
        chk("err_after_fallback", er[0], 1'b1);
        req_valid = 1'b0;
        step();

        // 5: reset in the middle of SETTLE.
        c2_half = 25; c2_en = 1'b1;
        j = 0;
        while (!alv[0] && j < 12) begin step(); j++; end
        chk("alive_again", alv[0], 1'b1);
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        req_valid = 1'b0;
        step(3);
        chk("mid_settle_busy", bsy[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_sel", sel[0], 1'b0);
        chk("rst_busy", bsy[0], 1'b0);
        step(2);
        rst = 1'b0;
        bad = 1'b0;
        repeat (12) begin step(); if (dn[0]) bad = 1'b1; end
        chk("no_done_after_rst", bad, 1'b0);

        // 6: settle of one cycle, back-to-back 0->1->0.
        j = 0;
        while (!alv[1] && j < 12) begin step(); j++; end
        req_valid = 1'b1; req_sel = 1'b1;
        step();
        chk("b2b_sel1", sel[1], 1'b1);
        chk("b2b_busy1", bsy[1], 1'b1);
        req_sel = 1'b0;
        step();
        chk("b2b_done1", dn[1], 1'b1);
        chk("b2b_hold1", sel[1], 1'b1);
        step();
        req_valid = 1'b0;
        chk("b2b_sel0", sel[1], 1'b0);
        chk("b2b_nodone", dn[1], 1'b0);
        step();
        chk("b2b_done0", dn[1], 1'b1);

        // Random traffic, clk2 start/stop and occasional resets.
        for (int it = 0; it < 1500; it++) begin
            req_valid = ($urandom_range(0, 2) == 0);
            req_sel   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 79) == 0) begin
                c2_en = !c2_en;
                if (!c2_en) c2_half = 5 + 10 * int'($urandom_range(1, 3));
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0; req_valid = 1'b0;
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
